reg_bank_arbiter: RTL and testbench

//   Shares one bank of DEPTH x WIDTH registers between N_REQ requesters.

---
 rtl/reg_bank_arbiter_if.sv | 30 +++
 rtl/reg_bank_arbiter.sv | 97 +++++++++
 tb/tb_reg_bank_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/reg_bank_arbiter_if.sv
// Bus bundle between N_REQ requesters and the shared register bank arbiter.
// Request fields are flat vectors sliced per requester; responses are shared.
interface reg_bank_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int N_REQ = 4
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int ID_W   = $clog2(N_REQ);

    logic [N_REQ-1:0]        i_req;
    logic [N_REQ-1:0]        i_we;
    logic [N_REQ*ADDR_W-1:0] i_addr;
    logic [N_REQ*WIDTH-1:0]  i_wdata;
    logic [N_REQ-1:0]        o_gnt;
    logic                    o_rvalid;
    logic [ID_W-1:0]         o_rid;
    logic [WIDTH-1:0]        o_rdata;
    logic                    o_err;

    modport master (
        output i_req, i_we, i_addr, i_wdata,
        input  o_gnt, o_rvalid, o_rid, o_rdata, o_err
    );

    modport slave (
        input  i_req, i_we, i_addr, i_wdata,
        output o_gnt, o_rvalid, o_rid, o_rdata, o_err
    );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter granting one read or write per cycle into a shared
// DEPTH x WIDTH register bank, with a registered read/error response.
module reg_bank_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int N_REQ = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    reg_bank_arbiter_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int ID_W   = $clog2(N_REQ);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    // Handshake: requester k holds i_req[k] and its fields stable until a
    // cycle with i_req[k] & o_gnt[k]; that cycle is the transfer. o_gnt is
    // combinational from i_req, so i_req must never depend on o_gnt.

    logic [WIDTH-1:0] r_bank [DEPTH];
    logic [ID_W-1:0]  r_ptr;
    logic             r_rvalid;
    logic [ID_W-1:0]  r_rid;
    logic [WIDTH-1:0] r_rdata;
    logic             r_err;

    logic             w_found;
    logic [ID_W-1:0]  w_idx;
    logic [N_REQ-1:0] w_gnt;
    logic             w_grant;
    logic             w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [WIDTH-1:0] w_sel_wdata;
    logic             w_in_range;
    logic [WIDTH-1:0] w_rd_word;

    // Scan from r_ptr upward with wrap; first asserted request wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && bus.i_req[(int'(r_ptr) + i) % N_REQ]) begin
                w_found = 1'b1;
                w_idx   = ID_W'((int'(r_ptr) + i) % N_REQ);
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        if (w_found && i_rst_n) begin
            w_gnt[w_idx] = 1'b1;
        end
    end

    assign w_grant     = |w_gnt;
    assign w_sel_we    = bus.i_we[w_idx];
    assign w_sel_addr  = bus.i_addr[w_idx*ADDR_W +: ADDR_W];
    assign w_sel_wdata = bus.i_wdata[w_idx*WIDTH +: WIDTH];
    assign w_in_range  = ({1'b0, w_sel_addr} < DEPTH_X);
    assign w_rd_word   = w_in_range ? r_bank[w_sel_addr] : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int d = 0; d < DEPTH; d++) begin
                r_bank[d] <= '0;
            end
            r_ptr    <= '0;
            r_rvalid <= 1'b0;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_grant && !w_sel_we;
            r_err    <= w_grant && !w_in_range;
            if (w_grant) begin
                r_ptr <= (w_idx == ID_W'(N_REQ-1)) ? '0 : w_idx + 1'b1;
                if (w_sel_we && w_in_range) begin
                    r_bank[w_sel_addr] <= w_sel_wdata;
                end
                if (!w_sel_we) begin
                    r_rdata <= w_rd_word;
                end
                // Error responses carry the requester id even for writes.
                if (!w_sel_we || !w_in_range) begin
                    r_rid <= w_idx;
                end
            end
        end
    end

    assign bus.o_gnt    = w_gnt;
    assign bus.o_rvalid = r_rvalid;
    assign bus.o_rid    = r_rid;
    assign bus.o_rdata  = r_rdata;
    assign bus.o_err    = r_err;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter with DEPTH=6 so out-of-range addresses exist.
module tb_reg_bank_arbiter;
    localparam int RW = 36;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  we;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic        rv;
        logic        err;
        logic [1:0]  rid;
        logic [31:0] rdata;
    } vec_t;

    logic i_clk = 1'b0;
    logic i_rst_n;
    int total = 0;
    int bad = 0;
    int vec_n = 0;
    logic [RW-1:0] exp_q[$];
    vec_t tbl[$];

    reg_bank_arbiter_if #(.WIDTH(32), .DEPTH(6), .N_REQ(4)) bus ();

    reg_bank_arbiter #(.WIDTH(32), .DEPTH(6), .N_REQ(4)) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic apply(input logic [3:0] req, input logic [3:0] we,
                         input logic [11:0] addr, input logic [127:0] wdata,
                         input logic [3:0] exp_gnt, input logic exp_rv,
                         input logic exp_err, input logic [1:0] exp_rid,
                         input logic [31:0] exp_rdata);
        logic [RW-1:0] e;
        bus.i_req   = req;
        bus.i_we    = we;
        bus.i_addr  = addr;
        bus.i_wdata = wdata;
        @(negedge i_clk);
        check($sformatf("gnt[%0d]", vec_n), 64'(bus.o_gnt), 64'(exp_gnt));
        exp_q.push_back({exp_rv, exp_err, exp_rid, exp_rdata});
        @(posedge i_clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("rvalid[%0d]", vec_n), 64'(bus.o_rvalid), 64'(e[35]));
        check($sformatf("err[%0d]", vec_n), 64'(bus.o_err), 64'(e[34]));
        if (e[35] || e[34]) check($sformatf("rid[%0d]", vec_n), 64'(bus.o_rid), 64'(e[33:32]));
        if (e[35]) check($sformatf("rdata[%0d]", vec_n), 64'(bus.o_rdata), 64'(e[31:0]));
        vec_n++;
    endtask

    task automatic add(input logic [3:0] req, input logic [3:0] we, input logic [2:0] a,
                       input logic [31:0] d, input logic [3:0] g, input logic rv,
                       input logic er, input logic [1:0] id, input logic [31:0] rd);
        vec_t v;
        v.req = req; v.we = we; v.addr = a; v.wdata = d;
        v.gnt = g; v.rv = rv; v.err = er; v.rid = id; v.rdata = rd;
        tbl.push_back(v);
    endtask

    initial begin
        // write/read basics, pointer starts at 1
        add(4'b0001, 4'b0001, 3'd3, 32'hDEADBEEF, 4'b0001, 0, 0, 2'd0, 32'h0);
        add(4'b0001, 4'b0000, 3'd3, 32'h0,        4'b0001, 1, 0, 2'd0, 32'hDEADBEEF);
        add(4'b0000, 4'b0000, 3'd0, 32'h0,        4'b0000, 0, 0, 2'd0, 32'h0);
        add(4'b0010, 4'b0010, 3'd1, 32'h11111111, 4'b0010, 0, 0, 2'd0, 32'h0);
        add(4'b0100, 4'b0100, 3'd2, 32'h22222222, 4'b0100, 0, 0, 2'd0, 32'h0);
        add(4'b1000, 4'b1000, 3'd5, 32'h55555555, 4'b1000, 0, 0, 2'd0, 32'h0);
        // round robin over all four, pointer wraps 3 -> 0
        for (int r = 0; r < 2; r++) begin
            add(4'b1111, 4'b0000, 3'd5, 32'h0, 4'b0001, 1, 0, 2'd0, 32'h55555555);
            add(4'b1111, 4'b0000, 3'd1, 32'h0, 4'b0010, 1, 0, 2'd1, 32'h11111111);
            add(4'b1111, 4'b0000, 3'd2, 32'h0, 4'b0100, 1, 0, 2'd2, 32'h22222222);
            add(4'b1111, 4'b0000, 3'd3, 32'h0, 4'b1000, 1, 0, 2'd3, 32'hDEADBEEF);
        end
        // fairness skip: ptr=2, requests {1,0} -> 0 then 1
        add(4'b0010, 4'b0000, 3'd1, 32'h0, 4'b0010, 1, 0, 2'd1, 32'h11111111);
        add(4'b0011, 4'b0000, 3'd2, 32'h0, 4'b0001, 1, 0, 2'd0, 32'h22222222);
        add(4'b0011, 4'b0000, 3'd2, 32'h0, 4'b0010, 1, 0, 2'd1, 32'h22222222);
        // out-of-range accesses from requester 2
        add(4'b0100, 4'b0100, 3'd7, 32'h55, 4'b0100, 0, 1, 2'd2, 32'h0);
        add(4'b0100, 4'b0000, 3'd7, 32'h0,  4'b0100, 1, 1, 2'd2, 32'h0);
        add(4'b0100, 4'b0100, 3'd6, 32'h55, 4'b0100, 0, 1, 2'd2, 32'h0);
        // bank contents unchanged by dropped writes
        add(4'b1000, 4'b0000, 3'd0, 32'h0, 4'b1000, 1, 0, 2'd3, 32'h0);
        add(4'b1000, 4'b0000, 3'd1, 32'h0, 4'b1000, 1, 0, 2'd3, 32'h11111111);
        add(4'b1000, 4'b0000, 3'd2, 32'h0, 4'b1000, 1, 0, 2'd3, 32'h22222222);
        add(4'b1000, 4'b0000, 3'd3, 32'h0, 4'b1000, 1, 0, 2'd3, 32'hDEADBEEF);
        add(4'b1000, 4'b0000, 3'd4, 32'h0, 4'b1000, 1, 0, 2'd3, 32'h0);
        add(4'b1000, 4'b0000, 3'd5, 32'h0, 4'b1000, 1, 0, 2'd3, 32'h55555555);
        // write direction follows the granted requester only
        add(4'b0110, 4'b0100, 3'd4, 32'h44444444, 4'b0010, 1, 0, 2'd1, 32'h0);
        add(4'b0110, 4'b0100, 3'd4, 32'h44444444, 4'b0100, 0, 0, 2'd0, 32'h0);
        add(4'b0010, 4'b0000, 3'd4, 32'h0,        4'b0010, 1, 0, 2'd1, 32'h44444444);

        // reset held with every requester asking
        i_rst_n = 1'b0;
        bus.i_req = 4'b1111; bus.i_we = '0; bus.i_addr = '0; bus.i_wdata = '0;
        @(posedge i_clk);
        #1;
        for (int c = 0; c < 2; c++) apply(4'b1111, 4'b0000, 12'h0, 128'h0, 4'b0000, 0, 0, 2'd0, 32'h0);
        check("reset_rid", 64'(bus.o_rid), 64'h0);
        check("reset_rdata", 64'(bus.o_rdata), 64'h0);
        i_rst_n = 1'b1;

        for (int a = 0; a < 6; a++) begin
            logic [2:0] aa;
            aa = 3'(a);
            apply(4'b0001, 4'b0000, {4{aa}}, 128'h0, 4'b0001, 1, 0, 2'd0, 32'h0);
        end

        foreach (tbl[i]) begin
            apply(tbl[i].req, tbl[i].we, {4{tbl[i].addr}}, {4{tbl[i].wdata}},
                  tbl[i].gnt, tbl[i].rv, tbl[i].err, tbl[i].rid, tbl[i].rdata);
        end

        // distinct per-requester slices, ptr=2 -> order 2,3,0,1
        apply(4'b1111, 4'b0000, {3'd5, 3'd3, 3'd2, 3'd1}, 128'h0, 4'b0100, 1, 0, 2'd2, 32'hDEADBEEF);
        apply(4'b1111, 4'b0000, {3'd5, 3'd3, 3'd2, 3'd1}, 128'h0, 4'b1000, 1, 0, 2'd3, 32'h55555555);
        apply(4'b1111, 4'b0000, {3'd5, 3'd3, 3'd2, 3'd1}, 128'h0, 4'b0001, 1, 0, 2'd0, 32'h11111111);
        apply(4'b1111, 4'b0000, {3'd5, 3'd3, 3'd2, 3'd1}, 128'h0, 4'b0010, 1, 0, 2'd1, 32'h22222222);
        apply(4'b0001, 4'b1111, {3'd4, 3'd3, 3'd2, 3'd0},
              {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0},
              4'b0001, 0, 0, 2'd0, 32'h0);
        apply(4'b0001, 4'b0000, 12'h0, 128'h0, 4'b0001, 1, 0, 2'd0, 32'hA0A0A0A0);

        // reset asserted in the same cycle as a read request
        i_rst_n = 1'b0;
        apply(4'b0010, 4'b0000, 12'h0, 128'h0, 4'b0000, 0, 0, 2'd0, 32'h0);
        i_rst_n = 1'b1;
        apply(4'b0000, 4'b0000, 12'h0, 128'h0, 4'b0000, 0, 0, 2'd0, 32'h0);
        apply(4'b1111, 4'b0000, 12'h0, 128'h0, 4'b0001, 1, 0, 2'd0, 32'h0);
        apply(4'b0001, 4'b0000, {4{3'd3}}, 128'h0, 4'b0001, 1, 0, 2'd0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
